// File: rtl/ahb_arb_pkg.sv
// Shared types and the round-robin pick helper for the AHB transaction arbiter.
package ahb_arb_pkg;

  typedef enum logic {ARB, HOLD} arb_state_t;

  // Upper bound on requesters; rr_pick works on vectors sized to this bound.
  localparam int MAX_REQ = 8;

  // First valid requester after 'last', searching last+1, last+2, ... modulo n_req.
  // The caller only uses the result when at least one valid bit is set.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [2:0]         last,
                                         input int                 n_req);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      idx = (int'(last) + i) % n_req;
      if (!found && (i <= n_req) && valid[idx]) begin
        pick  = 3'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/ahb_arb_tag_fifo.sv
// Small FIFO of requester IDs, one entry per outstanding read, in issue order.
module ahb_arb_tag_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 2
) (
  input  logic         i_clk_ahb,
  input  logic         i_rstn_ahb,
  input  logic         i_push,
  input  logic [W-1:0] i_push_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Pointers wrap at DEPTH explicitly so non-power-of-2 depths stay in range.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rd_ptr];
  // A pop in the same cycle frees the head slot, so a push into a full FIFO is legal then.
  assign w_do_push = i_push && (!o_full || i_pop);
  assign w_do_pop  = i_pop && !o_empty;

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage.
  // NOTE: the data array is not reset; r_count marks which entries are meaningful.
  always_ff @(posedge i_clk_ahb) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/ahb_txn_arbiter.sv
// Round-robin arbiter sharing one AHB master port among N_REQ requesters,
// with read-return routing back to the issuing requester.
module ahb_txn_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TAG_DEPTH = 2
) (
  input  logic                      i_clk_ahb,
  input  logic                      i_rstn_ahb,
  input  logic [N_REQ-1:0]          i_req_valid,
  input  logic [N_REQ-1:0]          i_req_rd0_wr1,
  input  logic [N_REQ*ADDR_W-1:0]   i_req_addr,
  input  logic [N_REQ*DATA_W-1:0]   i_req_wr_data,
  output logic [N_REQ-1:0]          o_req_ready,
  output logic [N_REQ-1:0]          o_req_rd_valid,
  output logic [DATA_W-1:0]         o_req_rd_data,
  output logic                      o_m_valid,
  output logic                      o_m_rd0_wr1,
  output logic [ADDR_W-1:0]         o_m_addr,
  output logic [DATA_W-1:0]         o_m_wr_data,
  input  logic                      i_m_ready,
  input  logic                      i_m_rd_valid,
  input  logic [DATA_W-1:0]         i_m_rd_data,
  output logic [$clog2(N_REQ)-1:0]  o_grant_id,
  output logic                      o_err_orphan
);

  localparam int ID_W = $clog2(N_REQ);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [ID_W-1:0]  r_grant_id;
  logic [ID_W-1:0]  r_last_grant;
  logic [ID_W-1:0]  w_pick;
  logic [MAX_REQ-1:0] w_valid_ext;
  logic             r_err_orphan;
  logic             w_is_rd;
  logic             w_push;
  logic             w_pop;
  logic             w_tag_full;
  logic             w_tag_empty;
  logic [ID_W-1:0]  w_tag_head;

  assign o_grant_id   = r_grant_id;
  assign o_err_orphan = r_err_orphan;

  // Widen the request vector to the helper's fixed width and pick the next winner.
  always_comb begin
    w_valid_ext              = '0;
    w_valid_ext[N_REQ-1:0]   = i_req_valid;
    w_pick                   = ID_W'(rr_pick(w_valid_ext, 3'(r_last_grant), N_REQ));
  end

  // State, grant registers and the sticky orphan-return flag.
  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      r_state      <= ARB;
      r_grant_id   <= '0;
      r_last_grant <= ID_W'(N_REQ - 1);
      r_err_orphan <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ARB && |i_req_valid) begin
        r_grant_id   <= w_pick;
        r_last_grant <= w_pick;
      end
      if (i_m_rd_valid && w_tag_empty) r_err_orphan <= 1'b1;
    end
  end

  // Next state, master-port mux and accept decode for the granted requester.
  // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    w_state_nxt = r_state;
    o_m_valid   = 1'b0;
    o_m_rd0_wr1 = 1'b0;
    o_m_addr    = '0;
    o_m_wr_data = '0;
    o_req_ready = '0;
    w_push      = 1'b0;
    w_is_rd     = 1'b0;
    case (r_state)
      ARB: begin
        if (|i_req_valid) w_state_nxt = HOLD;
      end
      HOLD: begin
        o_m_rd0_wr1 = i_req_rd0_wr1[r_grant_id];
        o_m_addr    = i_req_addr[int'(r_grant_id)*ADDR_W +: ADDR_W];
        o_m_wr_data = i_req_wr_data[int'(r_grant_id)*DATA_W +: DATA_W];
        w_is_rd     = !i_req_rd0_wr1[r_grant_id];
        // A read waits while every tag slot is taken; writes need no tag.
        o_m_valid   = i_req_valid[r_grant_id] && !(w_is_rd && w_tag_full);
        if (!i_req_valid[r_grant_id]) begin
          w_state_nxt = ARB;
        end else if (o_m_valid && i_m_ready) begin
          o_req_ready[r_grant_id] = 1'b1;
          w_push                  = w_is_rd;
          w_state_nxt             = ARB;
        end
      end
      default: w_state_nxt = ARB;
    endcase
  end

  // Read returns go to the oldest outstanding reader in the same cycle.
  always_comb begin
    o_req_rd_valid = '0;
    o_req_rd_data  = '0;
    w_pop          = i_m_rd_valid && !w_tag_empty;
    if (w_pop) begin
      o_req_rd_valid[w_tag_head] = 1'b1;
      o_req_rd_data              = i_m_rd_data;
    end
  end

  ahb_arb_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .W     (ID_W)
  ) u_tag_fifo (
    .i_clk_ahb   (i_clk_ahb),
    .i_rstn_ahb  (i_rstn_ahb),
    .i_push      (w_push),
    .i_push_data (r_grant_id),
    .i_pop       (w_pop),
    .o_head      (w_tag_head),
    .o_full      (w_tag_full),
    .o_empty     (w_tag_empty)
  );

endmodule

// File: tb/tb_ahb_txn_arbiter.sv
// Scoreboard bench for ahb_txn_arbiter: stimulus queues expected accepts and
// read returns; a negedge monitor compares them as the DUT presents them.
module tb_ahb_txn_arbiter;

  localparam int N_REQ     = 4;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int TAG_DEPTH = 2;
  localparam int ID_W      = 2;

  logic                     clk;
  logic                     rstn;
  logic [N_REQ-1:0]         i_req_valid;
  logic [N_REQ-1:0]         i_req_rd0_wr1;
  logic [N_REQ*ADDR_W-1:0]  i_req_addr;
  logic [N_REQ*DATA_W-1:0]  i_req_wr_data;
  logic [N_REQ-1:0]         o_req_ready;
  logic [N_REQ-1:0]         o_req_rd_valid;
  logic [DATA_W-1:0]        o_req_rd_data;
  logic                     o_m_valid;
  logic                     o_m_rd0_wr1;
  logic [ADDR_W-1:0]        o_m_addr;
  logic [DATA_W-1:0]        o_m_wr_data;
  logic                     i_m_ready;
  logic                     i_m_rd_valid;
  logic [DATA_W-1:0]        i_m_rd_data;
  logic [ID_W-1:0]          o_grant_id;
  logic                     o_err_orphan;

  ahb_txn_arbiter #(
    .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_DEPTH(TAG_DEPTH)
  ) dut (
    .i_clk_ahb      (clk),
    .i_rstn_ahb     (rstn),
    .i_req_valid    (i_req_valid),
    .i_req_rd0_wr1  (i_req_rd0_wr1),
    .i_req_addr     (i_req_addr),
    .i_req_wr_data  (i_req_wr_data),
    .o_req_ready    (o_req_ready),
    .o_req_rd_valid (o_req_rd_valid),
    .o_req_rd_data  (o_req_rd_data),
    .o_m_valid      (o_m_valid),
    .o_m_rd0_wr1    (o_m_rd0_wr1),
    .o_m_addr       (o_m_addr),
    .o_m_wr_data    (o_m_wr_data),
    .i_m_ready      (i_m_ready),
    .i_m_rd_valid   (i_m_rd_valid),
    .i_m_rd_data    (i_m_rd_data),
    .o_grant_id     (o_grant_id),
    .o_err_orphan   (o_err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [N_REQ-1:0]  ready;
    logic [ID_W-1:0]   gid;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } acc_t;

  typedef struct {
    logic [N_REQ-1:0]  onehot;
    logic [DATA_W-1:0] data;
  } ret_t;

  acc_t exp_acc[$];
  ret_t exp_ret[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every accept pulse and read-return pulse against the queues.
  initial begin
    acc_t ea;
    ret_t er;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (o_req_ready != '0) begin
          if (exp_acc.size() == 0) begin
            check("unexpected_accept", 64'(o_req_ready), 64'(0));
          end else begin
            ea = exp_acc.pop_front();
            check("acc_ready",  64'(o_req_ready), 64'(ea.ready));
            check("acc_grant",  64'(o_grant_id),  64'(ea.gid));
            check("acc_mvalid", 64'(o_m_valid),   64'(1));
            check("acc_rw",     64'(o_m_rd0_wr1), 64'(ea.rw));
            check("acc_addr",   64'(o_m_addr),    64'(ea.addr));
            check("acc_wdata",  64'(o_m_wr_data), 64'(ea.data));
          end
        end
        if (o_req_rd_valid != '0) begin
          if (exp_ret.size() == 0) begin
            check("unexpected_rd_valid", 64'(o_req_rd_valid), 64'(0));
          end else begin
            er = exp_ret.pop_front();
            check("ret_onehot", 64'(o_req_rd_valid), 64'(er.onehot));
            check("ret_data",   64'(o_req_rd_data),  64'(er.data));
          end
        end
      end
    end
  end

  task automatic clr_reqs();
    i_req_valid   = '0;
    i_req_rd0_wr1 = '0;
    i_req_addr    = '0;
    i_req_wr_data = '0;
  endtask

  task automatic set_req(input int k, input logic rw, input logic [31:0] a, input logic [31:0] d);
    i_req_valid[k]              = 1'b1;
    i_req_rd0_wr1[k]            = rw;
    i_req_addr[k*ADDR_W +: ADDR_W]    = a;
    i_req_wr_data[k*DATA_W +: DATA_W] = d;
  endtask

  task automatic push_acc(input int k, input logic rw, input logic [31:0] a, input logic [31:0] d);
    acc_t e;
    e.ready = N_REQ'(1) << k;
    e.gid   = ID_W'(k);
    e.rw    = rw;
    e.addr  = a;
    e.data  = d;
    exp_acc.push_back(e);
  endtask

  task automatic push_ret(input int k, input logic [31:0] d);
    ret_t e;
    e.onehot = N_REQ'(1) << k;
    e.data   = d;
    exp_ret.push_back(e);
  endtask

  // Bounded wait for the next accept pulse; reports the cycle it was seen on.
  task automatic wait_accept(input string name, output int at_cycle);
    at_cycle = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_req_ready != '0) begin
        at_cycle = cycle;
        return;
      end
    end
    n_checks++;
    n_errors++;
    $display("FAIL %s accept timeout actual=none expected=accept", name);
  endtask

  // One transaction from requester k, dropped the cycle after it is accepted.
  task automatic issue(input int k, input logic rw, input logic [31:0] a, input logic [31:0] d);
    int c;
    push_acc(k, rw, a, d);
    set_req(k, rw, a, d);
    wait_accept("issue", c);
    @(posedge clk); #1;
    i_req_valid[k] = 1'b0;
  endtask

  task automatic return_data(input logic [31:0] d);
    @(posedge clk); #1;
    i_m_rd_valid = 1'b1;
    i_m_rd_data  = d;
    @(posedge clk); #1;
    i_m_rd_valid = 1'b0;
    i_m_rd_data  = '0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"},    64'(o_req_ready),    64'(0));
    check({tag, "_rdvalid"},  64'(o_req_rd_valid), 64'(0));
    check({tag, "_rddata"},   64'(o_req_rd_data),  64'(0));
    check({tag, "_mvalid"},   64'(o_m_valid),      64'(0));
    check({tag, "_mrw"},      64'(o_m_rd0_wr1),    64'(0));
    check({tag, "_maddr"},    64'(o_m_addr),       64'(0));
    check({tag, "_mwdata"},   64'(o_m_wr_data),    64'(0));
    check({tag, "_grant"},    64'(o_grant_id),     64'(0));
    check({tag, "_orphan"},   64'(o_err_orphan),   64'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, c1, c2;

    rstn         = 1'b0;
    i_m_ready    = 1'b0;
    i_m_rd_valid = 1'b0;
    i_m_rd_data  = '0;
    clr_reqs();

    // Reset values, then idle after release.
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("idle_mvalid", 64'(o_m_valid), 64'(0));
    end

    // Round robin over four writers: grants 0,1,2,3,0.
    @(posedge clk); #1;
    i_m_ready = 1'b1;
    push_acc(0, 1'b1, 32'h1000, 32'hD0);
    push_acc(1, 1'b1, 32'h1001, 32'hD1);
    push_acc(2, 1'b1, 32'h1002, 32'hD2);
    push_acc(3, 1'b1, 32'h1003, 32'hD3);
    push_acc(0, 1'b1, 32'h1000, 32'hD0);
    for (int k = 0; k < N_REQ; k++) set_req(k, 1'b1, 32'h1000 + 32'(k), 32'hD0 + 32'(k));
    for (int i = 0; i < 5; i++) wait_accept("rr", c0);
    @(posedge clk); #1;
    clr_reqs();
    repeat (3) @(negedge clk);

    // A lone requester is re-granted every second cycle.
    for (int i = 0; i < 3; i++) push_acc(2, 1'b1, 32'h2000, 32'h22);
    set_req(2, 1'b1, 32'h2000, 32'h22);
    wait_accept("solo0", c0);
    wait_accept("solo1", c1);
    wait_accept("solo2", c2);
    @(posedge clk); #1;
    clr_reqs();
    check("solo_gap1", 64'(c1 - c0), 64'(2));
    check("solo_gap2", 64'(c2 - c1), 64'(2));
    repeat (3) @(negedge clk);

    // Forwarding while the master stalls, then valid withdrawn without transfer.
    i_m_ready = 1'b0;
    set_req(3, 1'b1, 32'h3000, 32'h33);
    repeat (2) @(negedge clk);
    check("stall_mvalid", 64'(o_m_valid),   64'(1));
    check("stall_grant",  64'(o_grant_id),  64'(3));
    check("stall_rw",     64'(o_m_rd0_wr1), 64'(1));
    check("stall_addr",   64'(o_m_addr),    64'(32'h3000));
    check("stall_wdata",  64'(o_m_wr_data), 64'(32'h33));
    @(posedge clk); #1;
    clr_reqs();
    @(negedge clk);
    check("drop_mvalid", 64'(o_m_valid), 64'(0));
    i_m_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Read routing: req2 then req1, returns go back in issue order.
    issue(2, 1'b0, 32'h100, 32'h0);
    issue(1, 1'b0, 32'h200, 32'h0);
    push_ret(2, 32'hAAAA);
    push_ret(1, 32'hBBBB);
    @(posedge clk); #1;
    i_m_rd_valid = 1'b1;
    i_m_rd_data  = 32'hAAAA;
    @(posedge clk); #1;
    i_m_rd_data  = 32'hBBBB;
    @(posedge clk); #1;
    i_m_rd_valid = 1'b0;
    i_m_rd_data  = '0;
    @(negedge clk);
    check("route_orphan", 64'(o_err_orphan), 64'(0));

    // Tag FIFO full: third read waits in HOLD until one return frees a slot.
    issue(0, 1'b0, 32'h10, 32'h0);
    issue(3, 1'b0, 32'h20, 32'h0);
    push_acc(1, 1'b0, 32'h30, 32'h0);
    set_req(1, 1'b0, 32'h30, 32'h0);
    repeat (4) begin
      @(negedge clk);
      check("full_mvalid", 64'(o_m_valid), 64'(0));
    end
    check("full_grant", 64'(o_grant_id), 64'(1));
    push_ret(0, 32'h1111);
    return_data(32'h1111);
    wait_accept("full_release", c0);
    @(posedge clk); #1;
    clr_reqs();
    push_ret(3, 32'h2222);
    push_ret(1, 32'h3333);
    return_data(32'h2222);
    return_data(32'h3333);
    @(negedge clk);
    check("full_orphan", 64'(o_err_orphan), 64'(0));

    // Orphan return: nothing routed, sticky error until reset.
    @(posedge clk); #1;
    i_m_rd_valid = 1'b1;
    i_m_rd_data  = 32'h5555;
    @(negedge clk);
    check("orphan_rdvalid", 64'(o_req_rd_valid), 64'(0));
    @(posedge clk); #1;
    i_m_rd_valid = 1'b0;
    i_m_rd_data  = '0;
    repeat (4) begin
      @(negedge clk);
      check("orphan_sticky", 64'(o_err_orphan), 64'(1));
    end
    @(posedge clk); #1;
    rstn = 1'b0;
    @(negedge clk);
    check_idle_outputs("orphan_reset");
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Reset with two reads outstanding discards their tags.
    issue(0, 1'b0, 32'h40, 32'h0);
    issue(2, 1'b0, 32'h50, 32'h0);
    @(posedge clk); #1;
    rstn = 1'b0;
    @(negedge clk);
    check("midrst_mvalid", 64'(o_m_valid),    64'(0));
    check("midrst_orphan", 64'(o_err_orphan), 64'(0));
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    i_m_rd_valid = 1'b1;
    i_m_rd_data  = 32'h6666;
    @(negedge clk);
    check("midrst_rdvalid", 64'(o_req_rd_valid), 64'(0));
    @(posedge clk); #1;
    i_m_rd_valid = 1'b0;
    i_m_rd_data  = '0;
    @(negedge clk);
    check("midrst_orphan_set", 64'(o_err_orphan), 64'(1));

    // Every queued expectation must have been consumed.
    repeat (2) @(negedge clk);
    check("acc_queue_left", 64'(exp_acc.size()), 64'(0));
    check("ret_queue_left", 64'(exp_ret.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
